// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access sizes,
// controller states, the response-pipeline control word, and the lane
// steering functions used on the store and load paths.
package dmem_pkg;

   localparam int DATA_W = 32;

   // Access size as encoded on req_size.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   // Controller state: zeroing the array, or serving requests.
   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Everything the response stage needs to know about an accepted request.
   typedef struct packed {
      logic       valid;
      logic       write;
      logic       err;
      logic [1:0] off;
      size_e      size;
      logic       uns;
   } resp_ctl_t;

   // Byte lanes touched by a store of the given size at the given offset.
   function automatic logic [3:0] byte_en(size_e size, logic [1:0] off);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Copy right-aligned store data into every lane so the byte enables
   // alone decide which lanes are written.
   function automatic logic [DATA_W-1:0] store_replicate(size_e size, logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] rep;
      case (size)
         SZ_BYTE: rep = {4{wdata[7:0]}};
         SZ_HALF: rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   // Pick the addressed lane(s) out of a little-endian word and extend to 32 bits.
   function automatic logic [DATA_W-1:0] load_extract(logic [DATA_W-1:0] word, logic [1:0] off,
                                                      size_e size, logic uns);
      logic [7:0]        b;
      logic [15:0]       h;
      logic [DATA_W-1:0] res;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
         SZ_WORD: res = word;
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage with a single shared port: byte-enabled
// synchronous write and registered synchronous read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [IDX_W-1:0]  addr_i,
   input  logic [3:0]        be_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Write enabled lanes and capture the read word on the same edge.
   // NOTE: the storage and read register carry no reset so they map onto
   // RAM macros; all state is updated with non-blocking assignments so the
   // read sees the pre-edge contents.
   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked data memory controller for the MEM stage. Optionally zeroes the
// array after reset, checks alignment/range/size at accept, steers store
// lanes, and returns extended load data through a 1- or 2-stage pipeline.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter  int DEPTH          = 64,
   parameter  int READ_LATENCY   = 1,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int ADDR_W         = $clog2(DEPTH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              clear_done
);

   localparam int               IDX_W       = ADDR_W - 2;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH - 1);
   localparam state_e           RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;

   logic              accept;
   size_e             req_sz;
   logic [IDX_W-1:0]  word_idx;
   logic              in_range;
   logic              req_err;

   logic              mem_we;
   logic              mem_re;
   logic [IDX_W-1:0]  mem_addr;
   logic [3:0]        mem_be;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   resp_ctl_t         s1_d, s1_q;
   logic [DATA_W-1:0] s1_rdata;
   logic              s1_err;

   // Ready depends on state alone, so a requester may wait on it freely.
   assign req_ready  = (state_q == ST_READY);
   assign clear_done = (state_q == ST_READY);
   assign accept     = req_valid & req_ready;
   assign req_sz     = size_e'(req_size);
   assign word_idx   = req_addr[ADDR_W-1:2];
   assign in_range   = 32'(word_idx) < 32'(DEPTH);

   // State register and clear counter; reset restarts any clear from word 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RESET_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: walk the array once, then stay in READY until reset.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_IDX) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Request legality: reserved size, misaligned half/word, or word index past DEPTH.
   always_comb begin
      req_err = !in_range;
      case (req_sz)
         SZ_HALF: if (req_addr[0])          req_err = 1'b1;
         SZ_WORD: if (req_addr[1:0] != 2'b00) req_err = 1'b1;
         SZ_RSVD: req_err = 1'b1;
         default: ;
      endcase
   end

   // Array port: clear writes own it during CLEAR, legal requests afterwards.
   always_comb begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = word_idx;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      if (state_q == ST_CLEAR) begin
         mem_we   = 1'b1;
         mem_addr = cnt_q;
         mem_be   = 4'b1111;
      end else if (accept && !req_err) begin
         if (req_write) begin
            mem_we    = 1'b1;
            mem_be    = byte_en(req_sz, req_addr[1:0]);
            mem_wdata = store_replicate(req_sz, req_wdata);
         end else begin
            mem_re = 1'b1;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .re_i    (mem_re),
      .addr_i  (mem_addr),
      .be_i    (mem_be),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   // Capture the request attributes the response stage needs at accept.
   always_comb begin
      s1_d       = s1_q;
      s1_d.valid = accept;
      if (accept) begin
         s1_d.write = req_write;
         s1_d.err   = req_err;
         s1_d.off   = req_addr[1:0];
         s1_d.size  = req_sz;
         s1_d.uns   = req_unsigned;
      end
   end

   // First response stage, aligned with the array read register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else begin
         s1_q <= s1_d;
      end
   end

   // Stores and erroring requests return zero data; loads get the selected lane.
   assign s1_rdata = (s1_q.valid && !s1_q.write && !s1_q.err)
                   ? load_extract(mem_rdata, s1_q.off, s1_q.size, s1_q.uns)
                   : '0;
   assign s1_err   = s1_q.valid & s1_q.err;

   if (READ_LATENCY == 2) begin : g_lat2
      logic              resp_valid_q;
      logic              resp_err_q;
      logic [DATA_W-1:0] resp_rdata_q;

      // Extra output register stage for the two-cycle latency option.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
         end else begin
            resp_valid_q <= s1_q.valid;
            resp_err_q   <= s1_err;
            resp_rdata_q <= s1_rdata;
         end
      end

      assign resp_valid = resp_valid_q;
      assign resp_err   = resp_err_q;
      assign resp_rdata = resp_rdata_q;
   end else begin : g_lat1
      assign resp_valid = s1_q.valid;
      assign resp_err   = s1_err;
      assign resp_rdata = s1_rdata;
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a latency-1 and a latency-2 instance
// share one request stream; a small non-power-of-two instance without clear
// covers the range check.
module tb_data_memory_ctrl;

   localparam logic [1:0] SZB = 2'b00;
   localparam logic [1:0] SZH = 2'b01;
   localparam logic [1:0] SZW = 2'b10;
   localparam logic [1:0] SZR = 2'b11;

   typedef struct {
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, b_valid;
   logic        req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;

   logic        r1_ready, r1_valid, r1_err, r1_done;
   logic [31:0] r1_rdata;
   logic        r2_ready, r2_valid, r2_err, r2_done;
   logic [31:0] r2_rdata;
   logic        r3_ready, r3_valid, r3_err, r3_done;
   logic [31:0] r3_rdata;

   int n_checks = 0;
   int n_err    = 0;

   bit          p_valid;
   logic        p_err;
   logic [31:0] p_rdata;

   vec_t vecs_a[$];
   vec_t vecs_b[$];

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH(64), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(r1_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r1_valid),
      .resp_rdata(r1_rdata), .resp_err(r1_err), .clear_done(r1_done));

   data_memory_ctrl #(.DEPTH(64), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(r2_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r2_valid),
      .resp_rdata(r2_rdata), .resp_err(r2_err), .clear_done(r2_done));

   data_memory_ctrl #(.DEPTH(5), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut3 (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(r3_ready),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr[4:0]), .req_wdata(req_wdata), .resp_valid(r3_valid),
      .resp_rdata(r3_rdata), .resp_err(r3_err), .clear_done(r3_done));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic wr, logic [1:0] sz, logic uns, logic [7:0] addr,
                               logic [31:0] wdata, logic err, logic [31:0] rd);
      vec_t v;
      v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_err = err; v.exp_rdata = rd;
      return v;
   endfunction

   // Present one request for one edge, then check the latency-1 response
   // and, on the shared stream, the latency-2 response of the previous one.
   task automatic apply_vec(input vec_t v, input bit to_b, input string tag);
      req_write    = v.wr;
      req_size     = v.sz;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      a_valid      = !to_b;
      b_valid      = to_b;
      @(posedge clk);
      #1;
      if (to_b) begin
         check({tag, "_valid"}, 32'(r3_valid), 32'd1);
         check({tag, "_err"},   32'(r3_err),   32'(v.exp_err));
         check({tag, "_rdata"}, r3_rdata,      v.exp_rdata);
      end else begin
         check({tag, "_valid"}, 32'(r1_valid), 32'd1);
         check({tag, "_err"},   32'(r1_err),   32'(v.exp_err));
         check({tag, "_rdata"}, r1_rdata,      v.exp_rdata);
         check({tag, "_lat2_valid"}, 32'(r2_valid), 32'(p_valid));
         if (p_valid) begin
            check({tag, "_lat2_err"},   32'(r2_err), 32'(p_err));
            check({tag, "_lat2_rdata"}, r2_rdata,    p_rdata);
         end
         p_valid = 1'b1;
         p_err   = v.exp_err;
         p_rdata = v.exp_rdata;
      end
   endtask

   // Count edges from now until ready rises; flag any response seen meanwhile.
   task automatic wait_clear(output int n, output bit stray);
      n = 0;
      stray = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (r1_valid || r2_valid) stray = 1'b1;
      end while (!r1_ready && n < 200);
   endtask

   task automatic idle_cycle();
      a_valid = 1'b0;
      b_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  n;
      bit  stray;

      // Shared stream: after clear, memory reads as zero everywhere.
      vecs_a.push_back(mk(0, SZW, 0, 8'h04, 32'h0,        0, 32'h00000000));
      vecs_a.push_back(mk(1, SZW, 0, 8'h00, 32'h12345678, 0, 32'h00000000));
      vecs_a.push_back(mk(0, SZB, 1, 8'h00, 32'h0,        0, 32'h00000078));
      vecs_a.push_back(mk(0, SZB, 1, 8'h01, 32'h0,        0, 32'h00000056));
      vecs_a.push_back(mk(0, SZB, 1, 8'h02, 32'h0,        0, 32'h00000034));
      vecs_a.push_back(mk(0, SZB, 1, 8'h03, 32'h0,        0, 32'h00000012));
      vecs_a.push_back(mk(1, SZB, 0, 8'h09, 32'hAAAAAA98, 0, 32'h00000000));
      vecs_a.push_back(mk(0, SZB, 0, 8'h09, 32'h0,        0, 32'hFFFFFF98));
      vecs_a.push_back(mk(0, SZB, 1, 8'h09, 32'h0,        0, 32'h00000098));
      vecs_a.push_back(mk(1, SZH, 0, 8'h0A, 32'h1234B898, 0, 32'h00000000));
      vecs_a.push_back(mk(0, SZW, 0, 8'h08, 32'h0,        0, 32'hB8989800));
      vecs_a.push_back(mk(0, SZH, 0, 8'h0A, 32'h0,        0, 32'hFFFFB898));
      vecs_a.push_back(mk(0, SZH, 0, 8'h08, 32'h0,        0, 32'hFFFF9800));
      vecs_a.push_back(mk(0, SZB, 0, 8'h0B, 32'h0,        0, 32'hFFFFFFB8));
      vecs_a.push_back(mk(0, SZH, 1, 8'h02, 32'h0,        0, 32'h00001234));
      vecs_a.push_back(mk(0, SZH, 0, 8'h00, 32'h0,        0, 32'h00005678));
      vecs_a.push_back(mk(0, SZB, 0, 8'h03, 32'h0,        0, 32'h00000012));
      vecs_a.push_back(mk(0, SZH, 0, 8'h01, 32'h0,        1, 32'h00000000));
      vecs_a.push_back(mk(1, SZW, 0, 8'h06, 32'hDEADBEEF, 1, 32'h00000000));
      vecs_a.push_back(mk(0, SZR, 0, 8'h04, 32'h0,        1, 32'h00000000));
      vecs_a.push_back(mk(0, SZW, 0, 8'h04, 32'h0,        0, 32'h00000000));
      vecs_a.push_back(mk(1, SZW, 0, 8'h04, 32'h56565656, 0, 32'h00000000));
      vecs_a.push_back(mk(0, SZW, 0, 8'h04, 32'h0,        0, 32'h56565656));
      vecs_a.push_back(mk(1, SZB, 0, 8'h0D, 32'h00000011, 0, 32'h00000000));
      vecs_a.push_back(mk(1, SZB, 0, 8'h0E, 32'h00000022, 0, 32'h00000000));
      vecs_a.push_back(mk(0, SZW, 0, 8'h0C, 32'h0,        0, 32'h00221100));
      vecs_a.push_back(mk(1, SZR, 0, 8'h0C, 32'hFFFFFFFF, 1, 32'h00000000));
      vecs_a.push_back(mk(0, SZW, 0, 8'h0C, 32'h0,        0, 32'h00221100));
      vecs_a.push_back(mk(0, SZW, 0, 8'hFC, 32'h0,        0, 32'h00000000));

      // DEPTH=5 instance: word indices 5..7 are out of range.
      vecs_b.push_back(mk(1, SZW, 0, 8'h10, 32'hCAFEF00D, 0, 32'h00000000));
      vecs_b.push_back(mk(0, SZW, 0, 8'h10, 32'h0,        0, 32'hCAFEF00D));
      vecs_b.push_back(mk(0, SZH, 1, 8'h12, 32'h0,        0, 32'h0000CAFE));
      vecs_b.push_back(mk(0, SZB, 0, 8'h10, 32'h0,        0, 32'h0000000D));
      vecs_b.push_back(mk(0, SZW, 0, 8'h14, 32'h0,        1, 32'h00000000));
      vecs_b.push_back(mk(1, SZW, 0, 8'h14, 32'h11111111, 1, 32'h00000000));
      vecs_b.push_back(mk(0, SZB, 1, 8'h1F, 32'h0,        1, 32'h00000000));
      vecs_b.push_back(mk(1, SZB, 0, 8'h13, 32'h00000077, 0, 32'h00000000));
      vecs_b.push_back(mk(0, SZW, 0, 8'h10, 32'h0,        0, 32'h77FEF00D));

      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0;
      req_write = 1'b0; req_size = SZW; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      p_valid = 1'b0; p_err = 1'b0; p_rdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ready",      32'(r1_ready), 32'd0);
      check("rst_clear_done", 32'(r1_done),  32'd0);
      check("rst_resp_valid", 32'(r1_valid), 32'd0);
      check("rst_resp_err",   32'(r1_err),   32'd0);
      check("rst_resp_rdata", r1_rdata,      32'd0);
      check("rst_lat2_valid", 32'(r2_valid), 32'd0);
      check("noclr_done",     32'(r3_done),  32'd1);

      rst = 1'b0;
      wait_clear(n, stray);
      check("clear_cycles",     32'(n),        32'd64);
      check("clear_done_set",   32'(r1_done),  32'd1);
      check("clear_no_resp",    32'(stray),    32'd0);
      check("lat2_ready",       32'(r2_ready), 32'd1);

      foreach (vecs_a[i]) apply_vec(vecs_a[i], 1'b0, $sformatf("a%0d", i));

      idle_cycle();
      check("idle_lat1_valid", 32'(r1_valid), 32'd0);
      check("tail_lat2_valid", 32'(r2_valid), 32'(p_valid));
      check("tail_lat2_rdata", r2_rdata,      p_rdata);
      p_valid = 1'b0;
      idle_cycle();
      check("idle_lat2_valid", 32'(r2_valid), 32'd0);

      // Two loads in flight, then reset: neither may ever respond.
      req_write = 1'b0; req_size = SZW; req_unsigned = 1'b0; req_addr = 8'h00;
      a_valid = 1'b1;
      @(posedge clk);
      #1;
      req_addr = 8'h04;
      @(posedge clk);
      #1;
      a_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("inflight_ready_drop", 32'(r1_ready), 32'd0);
      check("inflight_lat1_valid", 32'(r1_valid), 32'd0);
      check("inflight_lat2_valid", 32'(r2_valid), 32'd0);
      check("inflight_done_drop",  32'(r1_done),  32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_clear(n, stray);
      check("inflight_clear_cycles", 32'(n),     32'd64);
      check("inflight_no_resp",      32'(stray), 32'd0);

      // Reset while the clear is at word 30 restarts the full sweep.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("midclear_ready", 32'(r1_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("midclear_rst_done", 32'(r1_done), 32'd0);
      #2;
      rst = 1'b0;
      wait_clear(n, stray);
      check("midclear_restart_cycles", 32'(n), 32'd64);

      // Earlier contents must be gone after the clear.
      p_valid = 1'b0;
      apply_vec(mk(0, SZW, 0, 8'h00, 32'h0, 0, 32'h00000000), 1'b0, "post_clear_w0");
      apply_vec(mk(0, SZW, 0, 8'h0C, 32'h0, 0, 32'h00000000), 1'b0, "post_clear_w3");
      idle_cycle();
      p_valid = 1'b0;

      foreach (vecs_b[i]) apply_vec(vecs_b[i], 1'b1, $sformatf("b%0d", i));
      idle_cycle();
      check("b_idle_valid", 32'(r3_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Clocked, parametrised successor to the single-cycle data memory of the MIPS datapath.
- Byte-addressed, little-endian memory with byte, halfword and word loads and stores, sign or zero extension, and misalignment and range error reporting.
- Valid/ready request port; responses come back after a fixed pipelined latency.
- Optional power-up clear sequence; sits between the MEM stage and the word-array storage.

Parameters:
- DEPTH, 64: number of 32-bit words. Must be ≥2; need not be a power of two.
- READ_LATENCY, 1: cycles from request accept to resp_valid. Legal values are 1 and 2.
- CLEAR_ON_RESET, 1: when 1, all words are zeroed after reset before the first request is accepted.
- ADDR_W (localparam): $clog2(DEPTH)+2, the byte address width.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset; asynchronous, active-high.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_write, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned, input, 1: loads zero-extend when 1, sign-extend when 0. Ignored on stores.
- req_addr, input, ADDR_W: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in bits [7:0], half in bits [15:0]).
- resp_valid, output, 1: response strobe, one cycle per accepted request.
- resp_rdata, output, 32: extended load data. 0 for stores and for errors.
- resp_err, output, 1: request was misaligned, out of range or reserved size.
- clear_done, output, 1: high once the clear sequence is finished, or immediately when CLEAR_ON_RESET=0.

Behaviour:
- Reset values, applied asynchronously:
  - State: CLEAR if CLEAR_ON_RESET=1, else READY.
  - Clear counter: 0.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, all pipeline valids 0.
  - clear_done = !CLEAR_ON_RESET.
- State machine:
  - CLEAR: writes 0 to word[cnt], one word per cycle. After writing word DEPTH-1, goes to READY and sets clear_done=1.
  - READY: terminal state; stays there until rst.
- Handshake:
  - req_ready = (state==READY), combinational from state only; it never depends on req_valid.
  - Accept happens on a rising edge with req_valid && req_ready.
  - Throughput is one request per cycle; there is no back-pressure on responses.
- Error rules, evaluated at accept:
  - size 11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - word index addr[ADDR_W-1:2] ≥ DEPTH is an error.
  - An erroring request never modifies memory. It still produces a response with resp_err=1 and resp_rdata=0.
- Store:
  - Byte enables are derived from size and addr[1:0]. Byte goes to lane addr[1:0]; half goes to lanes {addr[1],0} and {addr[1],1}; word goes to all lanes.
  - Write data is replicated into the enabled lanes.
  - Memory updates at the accept edge.
- Load:
  - The word is read at the accept edge, and the lane is selected by the registered addr[1:0].
  - Extension depends on req_unsigned: sign extension uses bit 7 for a byte and bit 15 for a half.
- Latency:
  - resp_valid rises READY_LATENCY edges after the accept edge.
  - With READY_LATENCY=1, the response is visible in the cycle immediately following accept.
  - READ_LATENCY=2 adds one output register stage.
  - Responses are returned strictly in request order.
- Ordering hazards:
  - A store accepted at edge N followed by a load of the same word accepted at edge N+1: the load returns the new data (read-after-write is correct).
  - Back-to-back stores to different lanes of the same word both take effect.
- Reset mid-operation:
  - All in-flight responses are discarded.
  - A clear in progress restarts from word 0.
  - Memory contents are undefined if CLEAR_ON_RESET=0.

Decomposition:
- Package dmem_pkg holds:
  - Typedef size_e (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD).
  - Constant DATA_W=32.
  - Function for byte-enable generation from size and offset.
  - Function for load extract-and-extend from word, offset, size and unsigned flag.
- Sub-module dmem_array: DEPTH x 32 storage with 4-bit byte-enable synchronous write and synchronous read. The controller holds the FSM, the error check and the response pipeline.

Test Plan:
- Reset then clear, DEPTH=64: req_ready stays 0 for 64 cycles, then clear_done=1 and req_ready=1. A word load at address 0x04 returns 0x00000000.
- Store word 0x12345678 to 0x00, then byte loads at 0x00..0x03 with unsigned=1 → 0x78, 0x56, 0x34, 0x12. Each response appears 1 cycle after accept.
- Store byte 0x98 to 0x09, then load byte 0x09 with unsigned=0 → 0xFFFFFF98; with unsigned=1 → 0x00000098. Store half 0xB898 to 0x0A, then load word 0x08 → 0xB8989800 (with prior word 0 at that address).
- Misaligned and reserved requests: half load at 0x01, word store at 0x06, size 11 → each gives resp_err=1 and rdata 0. A word load at 0x04 afterwards shows memory unchanged.
- Back-to-back: store word 0x56565656 to 0x04 at edge N, load word 0x04 at edge N+1 → 0x56565656. With READ_LATENCY=2, three consecutive loads produce three in-order responses 2 cycles after their accepts.
- Assert rst while a clear is at word 30 → req_ready drops immediately and the clear restarts at 0 (64 more cycles). Assert rst with 2 loads in flight → no resp_valid is ever produced for them.
